chrono_time_core: RTL and testbench
===================================

CHRONO_TIME_CORE -- requirements
Module: chrono_time_core

Interface
REQ-001 The block SHALL have parameter MIN_LIMIT, default 59, the maximum minutes value before wrap-around (legal range 1..99).
REQ-002 The block SHALL have these ports:
- clk, input, 1, the single clock for all state.
- rst, input, 1, reset; synchronous and active-high.
- tick, input, 1, one-cycle 100 Hz (centisecond) pulse from the timebase pulse generator.
- start, input, 1, level or pulse; begin or resume counting.
- stop, input, 1, level or pulse; pause counting.
- clear, input, 1, zero all time digits and flags.
- lap, input, 1, one-cycle pulse; freeze or release the displayed time.
- csec_u, output, 4, centisecond units digit (BCD).
- csec_t, output, 4, centisecond tens digit (BCD).
- sec_u, output, 4, seconds units digit (BCD).
- sec_t, output, 4, seconds tens digit (BCD).
- min_u, output, 4, minutes units digit (BCD).
- min_t, output, 4, minutes tens digit (BCD).
- running, output, 1, high while the state is RUN.
- overflow, output, 1, sticky; set on wrap past MIN_LIMIT:59.99.
- lap_active, output, 1, high while the display is frozen.

Function
REQ-003 The FSM SHALL have states IDLE, RUN and HOLD, with all outputs registered.
REQ-004 Command priority per edge SHALL be: rst > clear > stop > start > tick.
REQ-005 Transitions SHALL be:
- IDLE -start-> RUN.
- RUN -stop-> HOLD.
- HOLD -start-> RUN.
- any state -clear-> IDLE.
- All other inputs leave the state unchanged.
REQ-006 Tick counting:
- A tick SHALL be counted only on an edge where the state is already RUN and stop and clear are low.
- A tick coincident with the start edge SHALL NOT be counted.
- Each counted tick SHALL update the digits, visible one cycle later; latency is 1 clk.
REQ-007 Digit rules:
- Each digit SHALL stay within BCD 0..9; csec_t stays within 0..9 and sec_t within 0..5.
- The carry chain SHALL be csec_u -> csec_t -> sec_u -> sec_t -> min_u -> min_t.
- All carries SHALL resolve in the same cycle.
REQ-008 Minute limit: when the time is MIN_LIMIT:59.99 and a tick is counted, the digits SHALL become 00:00.00, overflow SHALL set, and counting SHALL continue.
REQ-009 overflow SHALL stay high until clear or rst.
REQ-010 clear SHALL zero all digits, overflow and lap_active on the next edge, in any state, including mid-carry.
REQ-011 In HOLD and IDLE, digits SHALL hold and ticks SHALL be ignored.
REQ-012 stop while in IDLE and start while in RUN SHALL be no-ops.
REQ-013 Asserting start and stop together SHALL result in HOLD (or IDLE if the state was IDLE).

Reset
REQ-014 On rst high at a clk edge, the block SHALL enter IDLE, set all six digits to 0, and drive running=0, overflow=0 and lap_active=0.
REQ-015 rst SHALL override every input in the same cycle, including mid-count and mid-lap.
REQ-016 After rst deasserts, the block SHALL stay in IDLE until start.

Configuration
REQ-017 Macro CHRONO_LAP_EN SHALL select lap support.
REQ-018 With CHRONO_LAP_EN defined:
- A lap pulse in RUN with lap_active=0 SHALL copy the live digits to the display registers and set lap_active.
- Internal counting SHALL continue while lap_active=1.
- The next lap pulse SHALL clear lap_active, and the outputs SHALL show live digits from the following cycle.
- A lap pulse in IDLE or HOLD while lap_active=1 SHALL release the display.
- A lap pulse in IDLE or HOLD while lap_active=0 SHALL be ignored.
REQ-019 With CHRONO_LAP_EN undefined, lap SHALL be ignored, lap_active SHALL be tied 0, the outputs SHALL be the live digits, and no display registers SHALL be built.

Verification
REQ-020 The bench SHALL cover these scenarios:
- rst, then start, then 100 ticks -> 00:01.00, running=1, overflow=0.
- From 00:09.99 in RUN, 1 tick -> 00:10.00. From 00:59.99, 1 tick -> 01:00.00 next cycle.
- MIN_LIMIT=1, preload by ticking to 01:59.99, 1 tick -> 00:00.00 and overflow=1; overflow stays 1 until clear.
- RUN at 00:00.05, stop and tick in the same cycle -> HOLD at 00:00.05; 10 more ticks -> unchanged; start -> resumes from 05.
- start and tick in the same cycle from IDLE -> 00:00.00. clear while RUN at 00:12.34 -> IDLE, all 0.
- CHRONO_LAP_EN: lap at 00:03.00, then 50 ticks -> outputs 00:03.00 and lap_active=1; lap again -> 00:03.50 next cycle.

Source files
------------

// File: rtl/chrono_time_core.sv
// chrono_time_core: BCD stopwatch core (mm:ss.cc) with IDLE/RUN/HOLD control.
// Optional lap freeze display is enabled by defining CHRONO_LAP_EN.
module chrono_time_core #(
    parameter int MIN_LIMIT = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] csec_u,
    output logic [3:0] csec_t,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic       running,
    output logic       overflow,
    output logic       lap_active
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;
    localparam logic [3:0] LIM_T = 4'(MIN_LIMIT / 10);
    localparam logic [3:0] LIM_U = 4'(MIN_LIMIT % 10);
    state_t state, state_nxt;
    logic [23:0] tm, tm_nxt, tm_inc;
    logic [3:0] cs_u, cs_t, s_u, s_t, m_u, m_t;
    logic count, c0, c1, c2, c3, c4, at_limit;
    assign {m_t, m_u, s_t, s_u, cs_t, cs_u} = tm;
    always_comb begin
        count = state == RUN && tick && !stop;
        c0 = cs_u == 4'd9;
        c1 = c0 && cs_t == 4'd9;
        c2 = c1 && s_u == 4'd9;
        c3 = c2 && s_t == 4'd5;
        c4 = c3 && m_u == 4'd9;
        at_limit = c3 && m_u == LIM_U && m_t == LIM_T;
        tm_inc = at_limit ? 24'd0 : {c4 ? m_t + 4'd1 : m_t,
                                     c4 ? 4'd0 : c3 ? m_u + 4'd1 : m_u,
                                     c3 ? 4'd0 : c2 ? s_t + 4'd1 : s_t,
                                     c2 ? 4'd0 : c1 ? s_u + 4'd1 : s_u,
                                     c1 ? 4'd0 : c0 ? cs_t + 4'd1 : cs_t,
                                     c0 ? 4'd0 : cs_u + 4'd1};
        state_nxt = clear ? IDLE : stop ? (state == IDLE ? IDLE : HOLD) : start ? RUN : state;
        tm_nxt = clear ? 24'd0 : count ? tm_inc : tm;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            running <= 1'b0;
            overflow <= 1'b0;
            tm <= 24'd0;
        end else begin
            state <= state_nxt;
            running <= state_nxt == RUN;
            overflow <= !clear && (overflow || (count && at_limit));
            tm <= tm_nxt;
        end
    end
`ifdef CHRONO_LAP_EN
    // Display tracks the next live time unless frozen, so outputs stay registered.
    logic [23:0] disp;
    logic lap_nxt;
    always_comb lap_nxt = clear ? 1'b0 : !lap ? lap_active : lap_active ? 1'b0 : state == RUN;
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_active <= 1'b0;
            disp <= 24'd0;
        end else begin
            lap_active <= lap_nxt;
            disp <= lap_nxt ? disp : tm_nxt;
        end
    end
    assign {min_t, min_u, sec_t, sec_u, csec_t, csec_u} = disp;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign lap_active = 1'b0;
    assign {min_t, min_u, sec_t, sec_u, csec_t, csec_u} = tm;
`endif
endmodule

// File: tb/tb_chrono_time_core.sv
// tb_chrono_time_core: randomized + directed bench against a centisecond-count model.
// Two instances (MIN_LIMIT 59 and 1) share stimulus; CHRONO_LAP_EN selects lap expectations.
module tb_chrono_time_core;
    logic clk = 0, rst = 0, tick = 0, start = 0, stop = 0, clear = 0, lap = 0;
    wire [23:0] d0, d1;
    wire [2:0] f0, f1;
    int total = 0, bad = 0;
    bit chk = 0;
    int m_cs[2], m_fr[2], m_st;
    bit m_ov[2], m_lap, cnt;

    chrono_time_core dut0 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .csec_u(d0[3:0]), .csec_t(d0[7:4]), .sec_u(d0[11:8]), .sec_t(d0[15:12]),
        .min_u(d0[19:16]), .min_t(d0[23:20]),
        .running(f0[2]), .overflow(f0[1]), .lap_active(f0[0])
    );
    chrono_time_core #(.MIN_LIMIT(1)) dut1 (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .csec_u(d1[3:0]), .csec_t(d1[7:4]), .sec_u(d1[11:8]), .sec_t(d1[15:12]),
        .min_u(d1[19:16]), .min_t(d1[23:20]),
        .running(f1[2]), .overflow(f1[1]), .lap_active(f1[0])
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] bcd(input int cs);
        int m, s, c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic logic [26:0] expect_of(input int i);
        return {bcd(m_lap ? m_fr[i] : m_cs[i]), m_st == 1, m_ov[i], m_lap};
    endfunction

    // Model: time held as a plain centisecond count per instance; state 0=idle 1=run 2=hold.
    initial forever begin
        @(posedge clk);
        if (rst || clear) begin
            m_cs = '{0, 0};
            m_ov = '{0, 0};
            m_lap = 0;
            m_st = 0;
        end else begin
            cnt = m_st == 1 && tick && !stop;
`ifdef CHRONO_LAP_EN
            if (lap) begin
                if (m_lap) m_lap = 0;
                else if (m_st == 1) begin
                    m_lap = 1;
                    m_fr = m_cs;
                end
            end
`endif
            m_st = stop ? (m_st == 0 ? 0 : 2) : start ? 1 : m_st;
            if (cnt)
                for (int i = 0; i < 2; i++) begin
                    m_cs[i]++;
                    if (m_cs[i] == ((i == 1 ? 1 : 59) + 1) * 6000) begin
                        m_cs[i] = 0;
                        m_ov[i] = 1;
                    end
                end
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk) begin
            total += 2;
            if ({d0, f0} !== expect_of(0)) begin
                bad++;
                if (bad < 30) $display("FAIL model dut0: got %h/%b want %h/%b", d0, f0, expect_of(0) >> 3, expect_of(0) & 27'd7);
            end
            if ({d1, f1} !== expect_of(1)) begin
                bad++;
                if (bad < 30) $display("FAIL model dut1: got %h/%b want %h/%b", d1, f1, expect_of(1) >> 3, expect_of(1) & 27'd7);
            end
        end
    end

    task automatic lit(input string n, input logic [26:0] got, input logic [26:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h/%b want %h/%b", n, got[26:3], got[2:0], want[26:3], want[2:0]);
        end
    endtask

    task automatic step(input bit rs, tk, sa, so, cl, lp);
        {rst, tick, start, stop, clear, lap} = {rs, tk, sa, so, cl, lp};
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        repeat (n) step(0, 1, 0, 0, 0, 0);
    endtask

    initial begin
        step(1, 1, 1, 0, 0, 1);
        chk = 1;
        lit("reset0", {d0, f0}, {24'h000000, 3'b000});
        lit("reset1", {d1, f1}, {24'h000000, 3'b000});
        step(0, 0, 0, 0, 0, 0);
        lit("idle after rst", {d0, f0}, {24'h000000, 3'b000});
        step(0, 0, 1, 0, 0, 0);
        ticks(100);
        lit("100 ticks", {d0, f0}, {24'h000100, 3'b100});
        ticks(899);
        lit("9.99", {d0, f0}, {24'h000999, 3'b100});
        ticks(1);
        lit("10.00", {d0, f0}, {24'h001000, 3'b100});
        ticks(4999);
        lit("59.99", {d0, f0}, {24'h005999, 3'b100});
        ticks(1);
        lit("1:00.00", {d0, f0}, {24'h010000, 3'b100});
        ticks(5999);
        lit("lim1 1:59.99", {d1, f1}, {24'h015999, 3'b100});
        ticks(1);
        lit("lim1 wrap", {d1, f1}, {24'h000000, 3'b110});
        lit("lim59 2:00", {d0, f0}, {24'h020000, 3'b100});
        step(0, 0, 0, 1, 0, 0);
        lit("ovf after stop", {d1, f1}, {24'h000000, 3'b010});
        step(0, 0, 1, 0, 0, 0);
        lit("ovf after start", {d1, f1}, {24'h000000, 3'b110});
        step(0, 0, 0, 0, 1, 0);
        lit("ovf cleared", {d1, f1}, {24'h000000, 3'b000});
        step(0, 0, 1, 0, 0, 0);
        ticks(5);
        step(0, 1, 0, 1, 0, 0);
        lit("stop+tick", {d0, f0}, {24'h000005, 3'b000});
        ticks(10);
        lit("hold ignores ticks", {d0, f0}, {24'h000005, 3'b000});
        step(0, 0, 1, 0, 0, 0);
        ticks(1);
        lit("resume", {d0, f0}, {24'h000006, 3'b100});
        step(0, 0, 0, 0, 1, 0);
        step(0, 1, 1, 0, 0, 0);
        lit("start+tick", {d0, f0}, {24'h000000, 3'b100});
        ticks(1234);
        lit("12.34", {d0, f0}, {24'h001234, 3'b100});
        step(0, 1, 1, 1, 1, 0);
        lit("clear", {d0, f0}, {24'h000000, 3'b000});
        step(0, 0, 1, 0, 0, 0);
        ticks(300);
        step(0, 0, 0, 0, 0, 1);
`ifdef CHRONO_LAP_EN
        lit("lap set", {d0, f0}, {24'h000300, 3'b101});
        ticks(50);
        lit("lap frozen", {d0, f0}, {24'h000300, 3'b101});
`else
        lit("lap ignored", {d0, f0}, {24'h000300, 3'b100});
        ticks(50);
        lit("lap live", {d0, f0}, {24'h000350, 3'b100});
`endif
        step(0, 0, 0, 0, 0, 1);
        lit("lap release", {d0, f0}, {24'h000350, 3'b100});
        repeat (3000)
            step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0);
        chk = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
